seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Programmable serial-pattern detection controller. Arms and disarms a Moore-style bit-pattern matcher, holds its configuration, counts matches and enforces a no-match timeout.
- Hands each match to software or an upstream FSM through a valid/ack event interface.
- Sits between the serial bit source and the control plane, sequencing all detection activity.

Parameters:
- PAT_W, 4, pattern register width; also the maximum pattern length (legal range 2..7).
- PAT_RST, 4'b1101, pattern value loaded at reset.
- CNT_W, 8, match counter width.
- TO_W, 16, timeout counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- din_valid  in  1  din is sampled this cycle.
- din  in  1  serial data bit.
- arm  in  1  start or restart detection (level sampled per cycle).
- disarm  in  1  stop detection; priority over arm.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_W  pattern; bit 0 is the most recent bit.
- cfg_len  in  3  pattern length, 1..PAT_W.
- cfg_overlap  in  1  1 keeps history after a match; 0 clears it.
- cfg_oneshot  in  1  1 stops detection after the first match.
- cfg_timeout  in  TO_W  ARMED cycles without a match before timeout; 0 disables.
- evt_ack  in  1  consumer acknowledges the event.
- Y  out  1  match pulse, high while state is MATCH.
- evt_valid  out  1  sticky match event.
- overrun  out  1  a match occurred while evt_valid was still pending.
- to_flag  out  1  high while state is TIMEOUT.
- busy  out  1  state is ARMED or MATCH.
- cfg_rej  out  1  one-cycle pulse when a cfg_we is ignored.
- match_cnt  out  CNT_W  saturating count of matches since the last arm.
- state_o  out  3  current state encoding.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Config registers: pattern=PAT_RST, len=PAT_W, overlap=1, oneshot=0, timeout=0.
  - History shift register and history count clear.
  - Reset mid-operation aborts immediately; no event is generated.
- Config: cfg_we is accepted in IDLE, DONE or TIMEOUT. In ARMED or MATCH it is ignored and cfg_rej pulses for 1 cycle. cfg_len of 0 or greater than PAT_W is stored as PAT_W.
- History:
  - On each cycle with din_valid in ARMED or MATCH, din shifts into bit 0.
  - hist_cnt increments, saturating at PAT_W.
  - The window matches when hist_cnt (after the update) >= len and the low len bits equal pattern[len-1:0].
- States (state_o encoding): IDLE=0, ARMED=1, MATCH=2, DONE=3, TIMEOUT=4. Unused encodings go to IDLE.
- IDLE: arm -> ARMED; clear history, timer and match_cnt; clear overrun.
- ARMED, in priority order:
  - disarm -> IDLE.
  - arm -> ARMED restart (clears as in IDLE).
  - din_valid and window match -> MATCH.
  - cfg_timeout != 0 and timer == cfg_timeout-1 -> TIMEOUT.
  - Otherwise the timer increments.
  - A match beats a timeout in the same cycle.
- MATCH (lasts exactly one cycle per entry):
  - On entry: timer clears; if cfg_overlap=0, history and hist_cnt clear.
  - Bits are still sampled while in MATCH.
  - Exit: disarm -> IDLE; else oneshot -> DONE; else a new window match -> MATCH again (Y stays high); else -> ARMED.
- DONE and TIMEOUT: hold. arm -> ARMED (as from IDLE); disarm -> IDLE, with disarm winning.
- Y latency: the last pattern bit is sampled at edge k; Y is high from edge k to edge k+1.
- Event interface:
  - evt_valid sets on every MATCH entry and clears on evt_valid & evt_ack.
  - If a match entry and an ack occur in the same cycle, evt_valid stays 1.
  - A match entry while evt_valid=1 and no ack that cycle sets overrun (sticky until arm or reset).
- match_cnt increments on each MATCH entry and saturates at all-ones.

Test Plan:
- Reset defaults, arm, din_valid=1, din stream 1,1,0,1,1,0,1 -> Y pulses after bit 4 and after bit 7; match_cnt=2; evt_valid=1; overrun=1 when evt_ack is held 0.
- Same stream with cfg_overlap=0 -> a single Y pulse after bit 4; match_cnt=1; overrun=0.
- cfg_timeout=5, arm, din_valid=0 -> state ARMED for 5 cycles, then TIMEOUT; to_flag=1, busy=0. arm -> ARMED with match_cnt=0.
- cfg_oneshot=1, cfg_pattern=4'b0011, cfg_len=2, stream 1,1,1 -> MATCH after bit 2, then DONE; bit 3 is ignored; match_cnt=1.
- cfg_we while ARMED -> cfg_rej pulses once and the pattern is unchanged. disarm and arm asserted together in ARMED -> IDLE.
- rst_n=0 during MATCH with evt_valid=1 -> next cycle IDLE, all outputs 0, pattern=4'b1101.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: arms/disarms a bit-pattern
// matcher, holds its configuration, counts matches and enforces a no-match timeout.
module seq_det_ctrl #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
    parameter int               CNT_W   = 8,
    parameter int               TO_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             arm,
    input  logic             disarm,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic             cfg_oneshot,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             evt_ack,
    output logic             Y,
    output logic             evt_valid,
    output logic             overrun,
    output logic             to_flag,
    output logic             busy,
    output logic             cfg_rej,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_o
);

    localparam int               HC_W    = $clog2(PAT_W + 1);
    localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(PAT_W);
    localparam logic [2:0]       LEN_MAX = 3'(PAT_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_MATCH   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [PAT_W-1:0]  pattern_reg, pattern_next;
    logic [2:0]        len_reg, len_next;
    logic              overlap_reg, overlap_next;
    logic              oneshot_reg, oneshot_next;
    logic [TO_W-1:0]   timeout_reg, timeout_next;
    logic [PAT_W-1:0]  hist_reg, hist_next;
    logic [HC_W-1:0]   hist_cnt_reg, hist_cnt_next;
    logic [TO_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]  match_cnt_reg, match_cnt_next;
    logic              evt_valid_reg, evt_valid_next;
    logic              overrun_reg, overrun_next;
    logic              cfg_rej_reg, cfg_rej_next;

    logic [PAT_W-1:0]  len_mask;
    logic [PAT_W-1:0]  hist_shift;
    logic [HC_W-1:0]   hist_cnt_inc;
    logic              window_hit;
    logic              cfg_ok;
    logic              restart;
    logic              match_entry;

    // Only the low len bits of the history take part in the comparison.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign len_mask[gi] = (int'(len_reg) > gi);
    end

    assign hist_shift   = {hist_reg[PAT_W-2:0], din};
    assign hist_cnt_inc = (hist_cnt_reg == HC_MAX) ? HC_MAX : hist_cnt_reg + HC_W'(1);
    assign window_hit   = din_valid
                        && (int'(hist_cnt_inc) >= int'(len_reg))
                        && ((hist_shift & len_mask) == (pattern_reg & len_mask));
    assign cfg_ok       = (state_reg == S_IDLE) || (state_reg == S_DONE)
                        || (state_reg == S_TIMEOUT);

    always_comb begin
        state_next    = state_reg;
        hist_next     = hist_reg;
        hist_cnt_next = hist_cnt_reg;
        timer_next    = timer_reg;
        restart       = 1'b0;
        match_entry   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (arm) restart = 1'b1;
            end
            S_ARMED: begin
                if (disarm) begin
                    state_next = S_IDLE;
                end else if (arm) begin
                    restart = 1'b1;
                end else begin
                    if (din_valid) begin
                        hist_next     = hist_shift;
                        hist_cnt_next = hist_cnt_inc;
                    end
                    if (window_hit) begin
                        match_entry = 1'b1;
                    end else if ((timeout_reg != '0) && (timer_reg == timeout_reg - TO_W'(1))) begin
                        state_next = S_TIMEOUT;
                    end else begin
                        timer_next = timer_reg + TO_W'(1);
                    end
                end
            end
            S_MATCH: begin
                if (din_valid) begin
                    hist_next     = hist_shift;
                    hist_cnt_next = hist_cnt_inc;
                end
                if (disarm)           state_next = S_IDLE;
                else if (oneshot_reg) state_next = S_DONE;
                else if (window_hit)  match_entry = 1'b1;
                else                  state_next = S_ARMED;
            end
            S_DONE, S_TIMEOUT: begin
                if (disarm)   state_next = S_IDLE;
                else if (arm) restart = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase

        // A match entry resets the no-match timer; non-overlap mode also drops the history.
        if (match_entry) begin
            state_next = S_MATCH;
            timer_next = '0;
            if (!overlap_reg) begin
                hist_next     = '0;
                hist_cnt_next = '0;
            end
        end
        if (restart) begin
            state_next    = S_ARMED;
            hist_next     = '0;
            hist_cnt_next = '0;
            timer_next    = '0;
        end
    end

    always_comb begin
        pattern_next   = pattern_reg;
        len_next       = len_reg;
        overlap_next   = overlap_reg;
        oneshot_next   = oneshot_reg;
        timeout_next   = timeout_reg;
        match_cnt_next = match_cnt_reg;
        overrun_next   = overrun_reg;
        evt_valid_next = evt_valid_reg;
        cfg_rej_next   = cfg_we && !cfg_ok;

        if (cfg_we && cfg_ok) begin
            pattern_next = cfg_pattern;
            len_next     = ((cfg_len == 3'd0) || (int'(cfg_len) > PAT_W)) ? LEN_MAX : cfg_len;
            overlap_next = cfg_overlap;
            oneshot_next = cfg_oneshot;
            timeout_next = cfg_timeout;
        end

        if (evt_valid_reg && evt_ack) evt_valid_next = 1'b0;
        if (match_entry) begin
            evt_valid_next = 1'b1;
            if (match_cnt_reg != '1) match_cnt_next = match_cnt_reg + CNT_W'(1);
            if (evt_valid_reg && !evt_ack) overrun_next = 1'b1;
        end
        if (restart) begin
            match_cnt_next = '0;
            overrun_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            pattern_reg   <= PAT_RST;
            len_reg       <= LEN_MAX;
            overlap_reg   <= 1'b1;
            oneshot_reg   <= 1'b0;
            timeout_reg   <= '0;
            hist_reg      <= '0;
            hist_cnt_reg  <= '0;
            timer_reg     <= '0;
            match_cnt_reg <= '0;
            evt_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            cfg_rej_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pattern_reg   <= pattern_next;
            len_reg       <= len_next;
            overlap_reg   <= overlap_next;
            oneshot_reg   <= oneshot_next;
            timeout_reg   <= timeout_next;
            hist_reg      <= hist_next;
            hist_cnt_reg  <= hist_cnt_next;
            timer_reg     <= timer_next;
            match_cnt_reg <= match_cnt_next;
            evt_valid_reg <= evt_valid_next;
            overrun_reg   <= overrun_next;
            cfg_rej_reg   <= cfg_rej_next;
        end
    end

    assign Y         = (state_reg == S_MATCH);
    assign to_flag   = (state_reg == S_TIMEOUT);
    assign busy      = (state_reg == S_ARMED) || (state_reg == S_MATCH);
    assign evt_valid = evt_valid_reg;
    assign overrun   = overrun_reg;
    assign cfg_rej   = cfg_rej_reg;
    assign match_cnt = match_cnt_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: linear stimulus with hand-computed expectations
// checked by immediate assertions one clock edge at a time.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid, din, arm, disarm, cfg_we;
    logic [3:0]  cfg_pattern;
    logic [2:0]  cfg_len;
    logic        cfg_overlap, cfg_oneshot;
    logic [15:0] cfg_timeout;
    logic        evt_ack;
    logic        Y, evt_valid, overrun, to_flag, busy, cfg_rej;
    logic [7:0]  match_cnt;
    logic [2:0]  state_o;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, MATCH = 3'd2, DONE = 3'd3, TMO = 3'd4;

    seq_det_ctrl dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .arm(arm), .disarm(disarm), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_oneshot(cfg_oneshot),
        .cfg_timeout(cfg_timeout), .evt_ack(evt_ack), .Y(Y), .evt_valid(evt_valid),
        .overrun(overrun), .to_flag(to_flag), .busy(busy), .cfg_rej(cfg_rej),
        .match_cnt(match_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b);
        din_valid = 1'b1;
        din       = b;
        tick();
    endtask

    task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic ov,
                       input logic os, input logic [15:0] to);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
        cfg_overlap = ov; cfg_oneshot = os; cfg_timeout = to;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; arm = 1'b0; disarm = 1'b0;
        cfg_we = 1'b0; cfg_pattern = 4'h0; cfg_len = 3'd0; cfg_overlap = 1'b0;
        cfg_oneshot = 1'b0; cfg_timeout = 16'd0; evt_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_outs", {Y, evt_valid, overrun, to_flag, busy, cfg_rej}, 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);

        // Default pattern 1101, overlapping stream 1,1,0,1,1,0,1
        pulse_arm();
        chk("arm_state", 32'(state_o), 32'(ARMED));
        chk("arm_busy", 32'(busy), 32'd1);
        bit_in(1); bit_in(1); bit_in(0);
        chk("ov_b3_y", 32'(Y), 32'd0);
        bit_in(1);
        chk("ov_b4_y", 32'(Y), 32'd1);
        chk("ov_b4_cnt", 32'(match_cnt), 32'd1);
        chk("ov_b4_evt", 32'(evt_valid), 32'd1);
        chk("ov_b4_ovr", 32'(overrun), 32'd0);
        bit_in(1);
        chk("ov_b5_state", 32'(state_o), 32'(ARMED));
        bit_in(0);
        bit_in(1);
        chk("ov_b7_y", 32'(Y), 32'd1);
        chk("ov_b7_cnt", 32'(match_cnt), 32'd2);
        chk("ov_b7_ovr", 32'(overrun), 32'd1);
        din_valid = 1'b0;
        tick();
        chk("ov_after", 32'(state_o), 32'(ARMED));
        evt_ack = 1'b1; tick(); evt_ack = 1'b0;
        chk("ack_evt", 32'(evt_valid), 32'd0);
        chk("ack_ovr", 32'(overrun), 32'd1);
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk("disarm", 32'(state_o), 32'(IDLE));

        // Non-overlapping: only the first window matches
        cfg(4'b1101, 3'd4, 1'b0, 1'b0, 16'd0);
        chk("cfg_idle_rej", 32'(cfg_rej), 32'd0);
        pulse_arm();
        chk("no_arm_ovr", 32'(overrun), 32'd0);
        chk("no_arm_cnt", 32'(match_cnt), 32'd0);
        bit_in(1); bit_in(1); bit_in(0); bit_in(1);
        chk("no_b4_y", 32'(Y), 32'd1);
        bit_in(1);
        chk("no_b5_y", 32'(Y), 32'd0);
        bit_in(0); bit_in(1);
        chk("no_b7_y", 32'(Y), 32'd0);
        chk("no_b7_cnt", 32'(match_cnt), 32'd1);
        chk("no_b7_ovr", 32'(overrun), 32'd0);
        din_valid = 1'b0;
        disarm = 1'b1; tick(); disarm = 1'b0;

        // Timeout of 5 after a match; then match beats timeout on the same edge
        cfg(4'b1101, 3'd4, 1'b1, 1'b0, 16'd5);
        pulse_arm();
        bit_in(1); bit_in(1); bit_in(0); bit_in(1);
        chk("to_match", 32'(state_o), 32'(MATCH));
        din_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("to_armed5", 32'(state_o), 32'(ARMED));
        tick();
        chk("to_state", 32'(state_o), 32'(TMO));
        chk("to_flag", 32'(to_flag), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_cnt", 32'(match_cnt), 32'd1);
        pulse_arm();
        chk("rearm_state", 32'(state_o), 32'(ARMED));
        chk("rearm_cnt", 32'(match_cnt), 32'd0);
        chk("rearm_to", 32'(to_flag), 32'd0);
        tick();
        bit_in(1); bit_in(1); bit_in(0); bit_in(1);
        chk("to_vs_match", 32'(state_o), 32'(MATCH));
        din_valid = 1'b0;
        disarm = 1'b1; tick(); disarm = 1'b0;

        // One-shot, 2-bit pattern 11
        cfg(4'b0011, 3'd2, 1'b1, 1'b1, 16'd0);
        pulse_arm();
        bit_in(1);
        chk("os_b1", 32'(state_o), 32'(ARMED));
        bit_in(1);
        chk("os_b2", 32'(state_o), 32'(MATCH));
        bit_in(1);
        chk("os_b3", 32'(state_o), 32'(DONE));
        chk("os_cnt", 32'(match_cnt), 32'd1);
        chk("os_busy", 32'(busy), 32'd0);
        bit_in(1);
        chk("os_hold", 32'(state_o), 32'(DONE));
        din_valid = 1'b0;

        // Length 0 is stored as 4; cfg_we while armed is rejected
        cfg(4'b1101, 3'd0, 1'b1, 1'b0, 16'd0);
        pulse_arm();
        bit_in(1);
        din_valid = 1'b0;
        chk("len0_b1", 32'(state_o), 32'(ARMED));
        cfg(4'b0000, 3'd1, 1'b1, 1'b0, 16'd0);
        chk("rej_pulse", 32'(cfg_rej), 32'd1);
        tick();
        chk("rej_clear", 32'(cfg_rej), 32'd0);
        bit_in(1);
        bit_in(0);
        chk("rej_b3", 32'(state_o), 32'(ARMED));
        bit_in(1);
        chk("rej_b4", 32'(state_o), 32'(MATCH));
        din_valid = 1'b0;
        tick();
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        chk("dis_wins", 32'(state_o), 32'(IDLE));

        // Reset during MATCH restores the reset pattern
        cfg(4'b0110, 3'd4, 1'b1, 1'b0, 16'd0);
        pulse_arm();
        bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        chk("p0110_match", 32'(state_o), 32'(MATCH));
        chk("p0110_evt", 32'(evt_valid), 32'd1);
        din_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_state", 32'(state_o), 32'(IDLE));
        chk("mrst_outs", {Y, evt_valid, overrun, to_flag, busy, cfg_rej}, 32'd0);
        chk("mrst_cnt", 32'(match_cnt), 32'd0);
        pulse_arm();
        bit_in(1); bit_in(1); bit_in(0); bit_in(1);
        chk("mrst_pat", 32'(state_o), 32'(MATCH));
        din_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
